// File: rtl/rx_desc_gen.sv
// rx_desc_gen: RX descriptor generator.
// Takes the 256-bit framed stream from the MAC extractor, writes the frame
// words into the RX data FIFO, and after each frame pushes one 64-bit
// descriptor into the descriptor FIFO. Frames that cannot be stored are
// dropped whole, so each descriptor describes exactly the words written.
module rx_desc_gen #(
    parameter int unsigned MAX_BYTES    = 9600,
    parameter logic [12:0] DFIFO_THRESH = 13'h3C0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_data,
    input  logic         in_sop,
    input  logic         in_eop,
    input  logic [4:0]   in_mod,
    input  logic         in_err,
    output logic         dfifo_wr,
    output logic [255:0] dfifo_data,
    input  logic [12:0]  dfifo_usedw,
    output logic         cs_fifo_wr,
    output logic [63:0]  cs_fifo_din,
    input  logic         cs_fifo_full,
    output logic [15:0]  drop_cnt
);

    // Frame-level states.
    localparam logic [1:0] S_IDLE  = 2'd0;  // waiting for a start of frame
    localparam logic [1:0] S_FRAME = 2'd1;  // storing a frame
    localparam logic [1:0] S_DROP  = 2'd2;  // discarding until end of frame
    localparam logic [1:0] S_DESC  = 2'd3;  // emitting the descriptor

    logic [1:0]   state_q, state_d;
    logic [7:0]   seq_q, seq_d;
    logic [15:0]  words_q, words_d;     // data words written for this frame
    logic [5:0]   last_q, last_d;       // byte count of the last written word
    logic         err_q, err_d;
    logic         trunc_q, trunc_d;
    logic         pend_q, pend_d;       // drop the remainder after the descriptor
    logic [15:0]  drop_q, drop_d;
    logic         dfifo_wr_q, dfifo_wr_d;
    logic [255:0] dfifo_data_q;

    logic         accept;
    logic         desc_active;
    logic         sop_drop;
    logic [15:0]  byte_count;

    // Number of valid bytes in an end-of-frame beat; a zero modulo means a full beat.
    function automatic logic [5:0] mod_bytes(input logic [4:0] m);
        if (m == 5'd0) begin
            return 6'd32;
        end
        return {1'b0, m};
    endfunction

    // A further word may be stored while the bytes already written stay below the cap.
    function automatic logic has_room(input logic [15:0] w);
        logic [31:0] bytes;
        bytes = {16'd0, w} << 5;
        return bytes < MAX_BYTES;
    endfunction

    // Descriptor byte count. A truncated frame reports only what was stored; a
    // frame closed by a premature start of frame has its last word already
    // recorded as a full 32 bytes.
    function automatic logic [15:0] calc_byte_count(input logic [15:0] w,
                                                    input logic [5:0]  lb,
                                                    input logic        tr);
        logic [15:0] full_words;
        if (tr) begin
            return w << 5;
        end
        full_words = w - 16'd1;
        return (full_words << 5) + {10'd0, lb};
    endfunction

    assign accept      = in_valid & in_ready;
    assign in_ready    = (state_q != S_DESC);
    assign desc_active = (state_q == S_DESC);

    // The admission check only happens at start of frame; mid-frame the FIFO is
    // guaranteed room by the threshold, so it is never consulted again.
    assign sop_drop    = (dfifo_usedw > DFIFO_THRESH) | cs_fifo_full;
    assign byte_count  = calc_byte_count(words_q, last_q, trunc_q);

    // Next-state and per-frame bookkeeping.
    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        words_d    = words_q;
        last_d     = last_q;
        err_d      = err_q;
        trunc_d    = trunc_q;
        pend_d     = pend_q;
        drop_d     = drop_q;
        dfifo_wr_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Non-SOP beats in IDLE are stray and simply consumed.
                if (accept && in_sop) begin
                    if (sop_drop) begin
                        drop_d  = drop_q + 16'd1;
                        state_d = in_eop ? S_IDLE : S_DROP;
                    end else begin
                        dfifo_wr_d = 1'b1;
                        words_d    = 16'd1;
                        last_d     = in_eop ? mod_bytes(in_mod) : 6'd32;
                        err_d      = in_eop & in_err;
                        trunc_d    = 1'b0;
                        pend_d     = 1'b0;
                        state_d    = in_eop ? S_DESC : S_FRAME;
                    end
                end
            end

            S_FRAME: begin
                if (accept) begin
                    if (in_sop) begin
                        // Missing end of frame: close what we have as errored and
                        // discard the frame that just started.
                        err_d   = 1'b1;
                        pend_d  = 1'b1;
                        state_d = S_DESC;
                    end else begin
                        if (has_room(words_q)) begin
                            dfifo_wr_d = 1'b1;
                            words_d    = words_q + 16'd1;
                            last_d     = in_eop ? mod_bytes(in_mod) : 6'd32;
                        end else begin
                            trunc_d = 1'b1;
                        end
                        if (in_eop) begin
                            err_d   = in_err;
                            state_d = S_DESC;
                        end
                    end
                end
            end

            S_DROP: begin
                if (accept && in_eop) begin
                    state_d = S_IDLE;
                end
            end

            S_DESC: begin
                // The descriptor is written combinationally in this state; it
                // can coincide with the last data write but never precede it.
                if (!cs_fifo_full) begin
                    seq_d   = seq_q + 8'd1;
                    state_d = pend_q ? S_DROP : S_IDLE;
                    pend_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            seq_q      <= 8'd0;
            words_q    <= 16'd0;
            last_q     <= 6'd0;
            err_q      <= 1'b0;
            trunc_q    <= 1'b0;
            pend_q     <= 1'b0;
            drop_q     <= 16'd0;
            dfifo_wr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            words_q    <= words_d;
            last_q     <= last_d;
            err_q      <= err_d;
            trunc_q    <= trunc_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            dfifo_wr_q <= dfifo_wr_d;
        end
    end

    // Data FIFO write data, captured together with the write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            dfifo_data_q <= '0;
        end else if (dfifo_wr_d) begin
            dfifo_data_q <= in_data;
        end
    end

    assign dfifo_wr    = dfifo_wr_q;
    assign dfifo_data  = dfifo_data_q;
    assign drop_cnt    = drop_q;
    assign cs_fifo_wr  = desc_active & ~cs_fifo_full;
    assign cs_fifo_din = desc_active ?
                         {byte_count, words_q, err_q, trunc_q, 6'd0, seq_q, 16'd0} :
                         64'd0;

endmodule
